ps2_keyboard_rx: RTL
====================

# ps2_keyboard_rx

Parametrised PS/2 keyboard receiver that replaces the fixed 8-deep raw-byte receiver in the keyboard input path. It adds a glitch filter on ps2_clk, a frame timeout watchdog, error counting, a configurable-depth FIFO with overflow detection, and optional E0/F0 prefix decoding into key events. It sits between the PS/2 pins and the processor's keyboard MMIO/interrupt logic and keeps the ready/nextdata_n pop handshake.

## Interface
- FIFO_DEPTH, 8: FIFO entries; power of two, ≥2.
- FILTER_LEN, 4: consecutive equal clk samples required before the filtered ps2_clk changes level; ≥1.
- TIMEOUT_CYCLES, 10000: clk cycles without a sample event that abort a frame in progress.
- DECODE, 1: 1 = fold E0/F0 prefixes into ext/brk flags; 0 = raw bytes, ext=brk=0.
- clk  in  1  system clock.
- clr  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  PS/2 clock pin, asynchronous.
- ps2_data  in  1  PS/2 data pin, asynchronous.
- nextdata_n  in  1  active-low pop request, sampled at posedge clk.
- data  out  8  scan code at FIFO head; 0 when empty.
- ext  out  1  head entry had an E0 prefix; 0 when empty.
- brk  out  1  head entry had an F0 prefix (key release); 0 when empty.
- ready  out  1  FIFO non-empty.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky; set when a byte is dropped because the FIFO is full.
- err_cnt  out  8  saturating count of parity, start, stop and timeout errors.

## Operation
- Reset: all outputs 0. FSM goes to IDLE. Pointers, level, prefix flags, filter and timeout counters clear. The filtered clock level resets to 1.
- Inputs pass through a 2-FF synchronizer. The filter changes the filtered clock level only after FILTER_LEN consecutive synchronized samples disagree with it. A sample event is a 1→0 transition of the filtered clock.
- FSM states: IDLE, DATA, PARITY, STOP. Every transition happens on a sample event.
  - IDLE: if ps2_data=0, go to DATA with bit index 0. If ps2_data=1, stay in IDLE and increment err_cnt.
  - DATA: shift bits in LSB first. After bit 7, go to PARITY.
  - PARITY: latch the parity bit and go to STOP.
  - STOP: the frame is good if the 8 data bits plus parity have odd weight and ps2_data=1. A good frame is delivered to the decoder. A bad frame is discarded and increments err_cnt. Either way, return to IDLE.
- Timeout: in any state other than IDLE, a counter reaches TIMEOUT_CYCLES with no sample event → go to IDLE, increment err_cnt. The counter reloads on every sample event.
- Decoder with DECODE=1:
  - Byte E0 sets ext_pend and is not pushed.
  - Byte F0 sets brk_pend and is not pushed.
  - Any other byte is pushed as {ext_pend, brk_pend, byte}, then both pending flags clear.
  - Any frame error or timeout also clears both pending flags.
- Decoder with DECODE=0: every good byte is pushed with ext=brk=0.
- Push when full:
  - The entry is dropped and overflow is set.
  - Exception: if a pop happens in the same cycle, both the push and the pop proceed.
  - overflow clears only on clr.
- Pop: happens when nextdata_n=0 and ready=1 at posedge clk. Holding nextdata_n low pops one entry per cycle. A pop while empty is ignored.
- Pointers wrap modulo FIFO_DEPTH. err_cnt holds at 255.

## Timing
- ps2_clk pin fall → sample event registered: 3+FILTER_LEN clk cycles (2 for the synchronizer, FILTER_LEN for the filter, 1 for edge detect and FSM action).
- Stop-bit fall → ready=1, data valid: 3+FILTER_LEN cycles.
- Pop at edge N → next head on data/ext/brk and updated level after edge N.
- Simultaneous push and pop at level=1 → ready stays 1.
- ready, level and overflow are functions of registers only.
- clr asserted mid-frame: the partial frame is lost and no err_cnt increment occurs.

## Structure
- Package ps2_pkg holds:
  - PREFIX_EXT=8'hE0 and PREFIX_BRK=8'hF0;
  - the FSM state enum;
  - the FIFO entry layout {ext, brk, code[7:0]} (10 bits).
- Sub-module ps2_sync_filter (parameter FILTER_LEN) performs the synchronization, filtering and edge detection. It outputs sample_evt and data_s (synchronized ps2_data).
- The FIFO is inline, with a register array of FIFO_DEPTH×10 bits.

## Test plan
- Reset: assert clr mid-frame → all outputs 0; the next clean frame 0x1C is received correctly.
- Single frame: 0x1C with parity 0 → after the stop bit, ready=1, data=8'h1C, ext=0, brk=0, level=1, exactly 3+FILTER_LEN cycles after the stop fall.
- Prefixes:
  - DECODE=1, frames E0, F0, 75 → one entry: data=75, ext=1, brk=1.
  - DECODE=0, same frames → three entries E0, F0, 75, each with flags 0.
- Errors:
  - 0x1C sent with parity 1 → no push, err_cnt=1.
  - Then a frame with stop=0 → err_cnt=2.
  - Then a good 0x29 → data=29.
- Overflow: with FIFO_DEPTH=8, send 9 frames 01..09 and no pops → level=8, overflow=1. Popping 8 times yields 01..08. A push coinciding with a pop at full is accepted.
- Robustness:
  - A ps2_clk low glitch of FILTER_LEN-1 cycles → no sample event.
  - Start bit plus 3 data bits, then silence → after TIMEOUT_CYCLES the FSM is in IDLE and err_cnt=1. The next frame is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
package ps2_pkg;

    // Scan-code prefixes folded into flags by the decoder
    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    // Frame receiver states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    // One FIFO entry: {ext, brk, code}
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_entry_t;

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronises the PS/2 pins, debounces ps2_clk and flags its falling edges.
module ps2_sync_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic sample_evt,
    output logic data_s
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic          r_filt;
    logic          r_filt_d;
    logic [CW-1:0] r_cnt;

    // Two-flop synchronisers; reset to the idle-high bus level so no false edge follows reset
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
        end
    end

    // Filtered level follows the pin only after FILTER_LEN consecutive disagreeing samples
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
            r_cnt    <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (r_clk_sync[1] == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_filt <= r_clk_sync[1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Falling edge of the filtered clock; consumed by the frame FSM on the following edge
    assign sample_evt = r_filt_d & ~r_filt;
    assign data_s     = r_data_sync[1];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frame FSM, timeout, prefix decoder and pop-handshake FIFO.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int DECODE         = 1
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          nextdata_n,
    output logic [7:0]                    data,
    output logic                          ext,
    output logic                          brk,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic [7:0]                    err_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          w_sample_evt;
    logic          w_data_s;
    ps2_state_t    r_state;
    ps2_state_t    w_state_next;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [TW-1:0] r_to_cnt;
    logic          w_timeout;
    logic          w_frame_good;
    logic          w_frame_err;
    logic          r_ext_pend;
    logic          r_brk_pend;
    logic          w_push_req;
    ps2_entry_t    w_push_entry;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    ps2_entry_t    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_overflow;
    logic [7:0]    r_err_cnt;
    ps2_entry_t    w_head;

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sync_filter (
        .clk        (clk),
        .clr        (clr),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .sample_evt (w_sample_evt),
        .data_s     (w_data_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next state plus frame verdicts; timeout wins because it only fires without a sample event
    always_comb begin
        w_state_next = r_state;
        w_frame_good = 1'b0;
        w_frame_err  = 1'b0;
        w_timeout    = 1'b0;
        if (r_state != IDLE && !w_sample_evt && r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            w_timeout    = 1'b1;
            w_state_next = IDLE;
        end else if (w_sample_evt) begin
            case (r_state)
                IDLE: begin
                    if (!w_data_s) w_state_next = DATA;
                    else           w_frame_err  = 1'b1;
                end
                DATA: begin
                    if (r_bit_idx == 3'd7) w_state_next = PARITY;
                end
                PARITY: w_state_next = STOP;
                STOP: begin
                    w_state_next = IDLE;
                    if ((^{r_shift, r_parity}) && w_data_s) w_frame_good = 1'b1;
                    else                                    w_frame_err  = 1'b1;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Shift register, bit index and parity capture on sample events
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
        end else if (w_sample_evt) begin
            case (r_state)
                IDLE:    r_bit_idx <= '0;
                DATA: begin
                    r_shift   <= {w_data_s, r_shift[7:1]};
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
                PARITY:  r_parity <= w_data_s;
                default: ;
            endcase
        end
    end

    // Watchdog counts idle cycles inside a frame and reloads on every sample event
    always_ff @(posedge clk or posedge clr) begin
        if (clr)                              r_to_cnt <= '0;
        else if (r_state == IDLE || w_sample_evt) r_to_cnt <= '0;
        else                                  r_to_cnt <= r_to_cnt + TW'(1);
    end

    // Prefix bytes are swallowed into pending flags; everything else is pushed
    always_comb begin
        w_push_entry.ext  = (DECODE != 0) ? r_ext_pend : 1'b0;
        w_push_entry.brk  = (DECODE != 0) ? r_brk_pend : 1'b0;
        w_push_entry.code = r_shift;
        w_push_req        = w_frame_good &&
                            ((DECODE == 0) || (r_shift != PREFIX_EXT && r_shift != PREFIX_BRK));
    end

    // Pending prefix flags; any broken frame discards a half-built key event
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (w_frame_err || w_timeout) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (w_frame_good && DECODE != 0) begin
            if (r_shift == PREFIX_EXT) begin
                r_ext_pend <= 1'b1;
            end else if (r_shift == PREFIX_BRK) begin
                r_brk_pend <= 1'b1;
            end else begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end
        end
    end

    // A push into a full FIFO still lands if a pop frees the head slot in the same cycle
    assign w_full = (r_level == LW'(FIFO_DEPTH));
    assign w_pop  = !nextdata_n && (r_level != '0);
    assign w_push = w_push_req && (!w_full || w_pop);

    // FIFO storage; contents need no reset because the head is masked while empty
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_entry;
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_level <= r_level + LW'(1);
            else if (w_pop && !w_push) r_level <= r_level - LW'(1);
            if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    // Saturating error counter covering start, parity, stop and timeout errors
    always_ff @(posedge clk or posedge clr) begin
        if (clr)                                                  r_err_cnt <= '0;
        else if ((w_frame_err || w_timeout) && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign w_head   = r_mem[r_rd_ptr];
    assign ready    = (r_level != '0);
    assign data     = ready ? w_head.code : 8'h00;
    assign ext      = ready ? w_head.ext  : 1'b0;
    assign brk      = ready ? w_head.brk  : 1'b0;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign err_cnt  = r_err_cnt;

endmodule
